// File: rtl/divisor_frecuencia_param_if.sv
// Control and output bundle for the multi-channel frequency divider.
// The master modport drives divisors, modes and enables; the slave modport is the divider.
interface divisor_frecuencia_param_if #(
    parameter int WIDTH   = 16,
    parameter int CANALES = 4
);
    logic [CANALES*WIDTH-1:0] donde;
    logic [CANALES-1:0]       modo;
    logic [CANALES-1:0]       habilitar;
    logic                     sincronizar;
    logic [CANALES-1:0]       clk_out;
    logic [CANALES-1:0]       tick;

    modport master (
        output donde, modo, habilitar, sincronizar,
        input  clk_out, tick
    );

    modport slave (
        input  donde, modo, habilitar, sincronizar,
        output clk_out, tick
    );
endinterface

// File: rtl/divisor_frecuencia_param.sv
// Multi-channel programmable clock divider with shadowed divisor/mode per channel.
// New settings are loaded only at terminal count, while disabled, or on reset/sincronizar.
module divisor_frecuencia_param #(
    parameter int WIDTH   = 16,
    parameter int CANALES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    divisor_frecuencia_param_if.slave bus
);

    logic [CANALES-1:0][WIDTH-1:0] cuenta_q, cuenta_d;
    logic [CANALES-1:0][WIDTH-1:0] d_act_q,  d_act_d;
    logic [CANALES-1:0]            m_act_q,  m_act_d;
    logic [CANALES-1:0]            clk_out_q, clk_out_d;
    logic [CANALES-1:0]            tick_q,   tick_d;

    always_comb begin
        // NOTE: every next-state signal is given a default before any branch, so no latch is inferred.
        cuenta_d  = cuenta_q;
        d_act_d   = d_act_q;
        m_act_d   = m_act_q;
        clk_out_d = clk_out_q;
        tick_d    = '0;

        for (int i = 0; i < CANALES; i++) begin
            if (bus.sincronizar || !bus.habilitar[i]) begin
                // Idle or re-phasing: hold outputs low and keep the shadow tracking the inputs.
                cuenta_d[i]  = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
                d_act_d[i]   = bus.donde[i*WIDTH +: WIDTH];
                m_act_d[i]   = bus.modo[i];
            end else if (cuenta_q[i] == d_act_q[i]) begin
                // Period boundary: the only point where a running channel accepts new settings.
                cuenta_d[i]  = '0;
                tick_d[i]    = 1'b1;
                clk_out_d[i] = m_act_q[i] ? 1'b1 : ~clk_out_q[i];
                d_act_d[i]   = bus.donde[i*WIDTH +: WIDTH];
                m_act_d[i]   = bus.modo[i];
            end else begin
                cuenta_d[i] = cuenta_q[i] + WIDTH'(1);
                tick_d[i]   = 1'b0;
                if (m_act_q[i]) begin
                    clk_out_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            cuenta_q  <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            m_act_q   <= bus.modo;
            for (int i = 0; i < CANALES; i++) begin
                d_act_q[i] <= bus.donde[i*WIDTH +: WIDTH];
            end
        end else begin
            cuenta_q  <= cuenta_d;
            d_act_q   <= d_act_d;
            m_act_q   <= m_act_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_divisor_frecuencia_param.sv
// Directed and randomized checks of divisor_frecuencia_param against a schedule-based model.
// The model tracks, per channel, the absolute edge index of the next terminal count.
module tb_divisor_frecuencia_param;

    localparam int W = 16;
    localparam int C = 4;

    logic clk;
    logic reset;

    divisor_frecuencia_param_if #(.WIDTH(W), .CANALES(C)) bus ();

    divisor_frecuencia_param #(.WIDTH(W), .CANALES(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int           now;
    int           next_tc [C];
    bit [C-1:0]   m_act;
    logic [C-1:0] e_out;
    logic [C-1:0] e_tick;

    task automatic set_d(input int ch, input int v);
        bus.donde[ch*W +: W] = W'(v);
    endtask

    task automatic model_edge();
        int d;
        now++;
        for (int i = 0; i < C; i++) begin
            d = int'(bus.donde[i*W +: W]);
            if (reset || bus.sincronizar || !bus.habilitar[i]) begin
                next_tc[i] = now + d + 1;
                m_act[i]   = bus.modo[i];
                e_out[i]   = 1'b0;
                e_tick[i]  = 1'b0;
            end else if (now == next_tc[i]) begin
                e_tick[i]  = 1'b1;
                e_out[i]   = m_act[i] ? 1'b1 : ~e_out[i];
                m_act[i]   = bus.modo[i];
                next_tc[i] = now + d + 1;
            end else begin
                e_tick[i] = 1'b0;
                if (m_act[i]) e_out[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
        assert (bus.clk_out === e_out) else begin
            miscompares++;
            $error("FAIL clk_out edge=%0d got=%b exp=%b", now, bus.clk_out, e_out);
        end
        vectors++;
        assert (bus.tick === e_tick) else begin
            miscompares++;
            $error("FAIL tick edge=%0d got=%b exp=%b", now, bus.tick, e_tick);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        now             = 0;
        m_act           = '0;
        e_out           = '0;
        e_tick          = '0;
        for (int i = 0; i < C; i++) next_tc[i] = 0;
        reset           = 1'b1;
        bus.sincronizar = 1'b0;
        bus.habilitar   = '0;
        bus.modo        = '0;
        for (int i = 0; i < C; i++) set_d(i, 3);
        run(2);

        // Basic toggle on ch0, D=3
        reset = 1'b0;
        bus.habilitar = 4'b0001;
        run(24);

        // Pulse mode on ch1, D=4, then D=0
        set_d(1, 4);
        bus.modo[1] = 1'b1;
        bus.habilitar[1] = 1'b1;
        run(16);
        set_d(1, 0);
        run(12);

        // Reload mid-period on ch0: 9 then 2
        set_d(0, 9);
        run(5);
        set_d(0, 2);
        run(20);

        // Mode switch mid-period on ch2, D=5
        set_d(2, 5);
        bus.habilitar[2] = 1'b1;
        run(8);
        bus.modo[2] = 1'b1;
        run(16);

        // Phase alignment with sincronizar
        bus.modo = '0;
        set_d(0, 3); set_d(2, 3); set_d(3, 7);
        run(3);
        bus.habilitar[3] = 1'b1;
        run(5);
        bus.sincronizar = 1'b1;
        run(1);
        bus.sincronizar = 1'b0;
        run(40);

        // Reset mid-operation
        run(2);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(10);

        // Drop enable on ch0
        bus.habilitar[0] = 1'b0;
        run(10);
        bus.habilitar[0] = 1'b1;
        run(10);

        // Reset and sincronizar together
        reset = 1'b1;
        bus.sincronizar = 1'b1;
        run(1);
        reset = 1'b0;
        bus.sincronizar = 1'b0;
        run(6);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < C; i++) begin
                if ($urandom_range(0, 15) == 0)
                    set_d(i, ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 7)));
                if ($urandom_range(0, 31) == 0) bus.modo[i] = ~bus.modo[i];
                if ($urandom_range(0, 39) == 0) bus.habilitar[i] = ~bus.habilitar[i];
            end
            bus.sincronizar = ($urandom_range(0, 99) == 0);
            reset           = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
